// File: rtl/ebpc_expander.sv
// Zero-expander for a bit-plane-compressed stream: merges a zero/non-zero flag stream with
// the decoded non-zero words, then discards the padding words that finish a partial block.
module ebpc_expander #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              znz_i,
  input  logic              znz_last_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  input  logic [DATA_W-1:0] bpc_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i
);

  localparam int CW = $clog2(BLOCK_SIZE);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] nz_cnt;
  logic [CW-1:0] nz_inc;
  logic          flush;
  logic          slot_free;
  logic          flag_xfer;
  logic          bpc_xfer;

  assign flush     = rst_i | clr_i;
  assign slot_free = !vld_o | rdy_i;
  assign nz_inc    = nz_cnt + CW'(1);

  // A non-zero flag is only accepted together with its word, so both handshakes
  // always complete in the same cycle while running.
  always_comb begin
    znz_rdy_o = 1'b0;
    bpc_rdy_o = 1'b0;
    if (!flush) begin
      if (state == RUN) begin
        znz_rdy_o = slot_free & (!znz_i | bpc_vld_i);
        bpc_rdy_o = znz_vld_i & znz_i & slot_free;
      end else begin
        bpc_rdy_o = 1'b1;
      end
    end
  end

  assign flag_xfer = znz_vld_i & znz_rdy_o;
  assign bpc_xfer  = bpc_vld_i & bpc_rdy_o;

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state  <= RUN;
      nz_cnt <= '0;
      data_o <= '0;
      last_o <= 1'b0;
      vld_o  <= 1'b0;
    end else begin
      if (bpc_xfer) nz_cnt <= nz_inc;
      if (state == RUN) begin
        if (flag_xfer) begin
          data_o <= znz_i ? bpc_i : '0;
          last_o <= znz_last_i;
          vld_o  <= 1'b1;
          // a partially filled block leaves padding words to throw away
          if (znz_last_i && ((znz_i ? nz_inc : nz_cnt) != '0)) state <= DRAIN;
        end else if (rdy_i) begin
          vld_o <= 1'b0;
        end
      end else begin
        if (rdy_i) vld_o <= 1'b0;
        if (bpc_xfer && (nz_inc == '0)) state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_ebpc_expander.sv
// Bench for ebpc_expander: handshake table, directed corner sequences and a
// scoreboarded random run with stalls on every port.
module tb_ebpc_expander;
  localparam int DW = 8;
  localparam int BS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, znz, znz_last, znz_vld, znz_rdy, bpc_vld, bpc_rdy, last, vld, rdy;
  logic [DW-1:0] bpc, data;

  logic s_znz, s_last_in, s_znz_vld, s_znz_rdy, s_bpc_vld, s_bpc_rdy, s_last, s_vld;
  logic [DW-1:0] s_bpc, s_data;

  ebpc_expander #(.DATA_W(DW), .BLOCK_SIZE(BS)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .znz_i(znz), .znz_last_i(znz_last), .znz_vld_i(znz_vld), .znz_rdy_o(znz_rdy),
    .bpc_i(bpc), .bpc_vld_i(bpc_vld), .bpc_rdy_o(bpc_rdy),
    .data_o(data), .last_o(last), .vld_o(vld), .rdy_i(rdy)
  );

  ebpc_expander #(.DATA_W(DW), .BLOCK_SIZE(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .znz_i(s_znz), .znz_last_i(s_last_in), .znz_vld_i(s_znz_vld), .znz_rdy_o(s_znz_rdy),
    .bpc_i(s_bpc), .bpc_vld_i(s_bpc_vld), .bpc_rdy_o(s_bpc_rdy),
    .data_o(s_data), .last_o(s_last), .vld_o(s_vld), .rdy_i(1'b1)
  );

  typedef struct packed {logic z; logic l;} flag_t;
  typedef struct packed {logic z; logic zv; logic bv; logic e_zr; logic e_br;} rdy_vec_t;

  int vectors = 0;
  int errors  = 0;

  flag_t         flag_q[$];
  logic [DW-1:0] bpc_q[$];
  logic [DW:0]   exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail(string name);
    vectors++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic bit chance(int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0;
    znz = 1'b0; znz_last = 1'b0; znz_vld = 1'b0; bpc = '0; bpc_vld = 1'b0; rdy = 1'b0;
    s_znz = 1'b0; s_last_in = 1'b0; s_znz_vld = 1'b0; s_bpc = '0; s_bpc_vld = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic add_stream(int n, int pct_nz);
    int k;
    logic z, l;
    logic [DW-1:0] w;
    k = 0;
    for (int i = 0; i < n; i++) begin
      z = chance(pct_nz);
      l = (i == n - 1);
      flag_q.push_back({z, l});
      if (z) begin
        w = DW'($urandom);
        bpc_q.push_back(w);
        exp_q.push_back({l, w});
        k++;
      end else begin
        exp_q.push_back({l, {DW{1'b0}}});
      end
    end
    repeat ((BS - (k % BS)) % BS) bpc_q.push_back(DW'($urandom));
  endtask

  task automatic drive_flags(int idle);
    flag_t f;
    int guard;
    bit done;
    while (flag_q.size() > 0) begin
      while (chance(idle)) tick();
      f = flag_q[0];
      znz = f.z; znz_last = f.l; znz_vld = 1'b1;
      guard = 0;
      done = 1'b0;
      do begin
        @(negedge clk);
        done = znz_rdy;
        tick();
        guard++;
      end while (!done && guard < 2000);
      znz_vld = 1'b0;
      if (done) flag_q.pop_front();
      else begin
        fail("flag_accept");
        flag_q.delete();
      end
    end
  endtask

  task automatic drive_bpc(int idle);
    int guard;
    bit done;
    while (bpc_q.size() > 0) begin
      while (chance(idle)) tick();
      bpc = bpc_q[0]; bpc_vld = 1'b1;
      guard = 0;
      done = 1'b0;
      do begin
        @(negedge clk);
        done = bpc_rdy;
        tick();
        guard++;
      end while (!done && guard < 2000);
      bpc_vld = 1'b0;
      if (done) void'(bpc_q.pop_front());
      else begin
        fail("bpc_accept");
        bpc_q.delete();
      end
    end
  endtask

  task automatic consume(int stall, int n);
    int got, guard;
    logic [DW:0] e;
    got = 0;
    guard = 0;
    while (got < n && guard < n * 200 + 1000) begin
      rdy = !chance(stall);
      @(negedge clk);
      if (vld && rdy) begin
        e = exp_q.pop_front();
        check("out_data", 32'(data), 32'(e[DW-1:0]));
        check("out_last", 32'(last), 32'(e[DW]));
        got++;
      end
      tick();
      guard++;
    end
    rdy = 1'b1;
    if (got < n) fail("output_count");
  endtask

  task automatic run_stream(int idle, int stall);
    int n;
    n = exp_q.size();
    fork
      drive_flags(idle);
      drive_bpc(idle);
      consume(stall, n);
    join
    @(negedge clk);
    check("no_extra_out", 32'(vld), 32'd0);
    check("bpc_left", 32'(bpc_q.size()), 32'd0);
    check("end_nz_cnt", 32'(dut.nz_cnt), 32'd0);
    check("end_not_drain", 32'(bpc_rdy), 32'd0);
  endtask

  rdy_vec_t tbl[8];
  logic [DW-1:0] s_words[4];
  int total;

  initial begin
    // z zv bv | expected znz_rdy bpc_rdy, idle RUN with an empty output slot
    tbl[0] = 5'b00010; tbl[1] = 5'b00110; tbl[2] = 5'b01010; tbl[3] = 5'b01110;
    tbl[4] = 5'b10000; tbl[5] = 5'b10110; tbl[6] = 5'b11001; tbl[7] = 5'b11111;
    s_words[0] = 8'h00; s_words[1] = 8'h11; s_words[2] = 8'h00; s_words[3] = 8'h22;

    rst = 1'b1; clr = 1'b0; rdy = 1'b0;
    znz = 1'b1; znz_last = 1'b0; znz_vld = 1'b1; bpc = 8'h77; bpc_vld = 1'b1;
    s_znz = 1'b0; s_last_in = 1'b0; s_znz_vld = 1'b0; s_bpc = '0; s_bpc_vld = 1'b0;
    #1;
    check("rst_znz_rdy", 32'(znz_rdy), 32'd0);
    check("rst_bpc_rdy", 32'(bpc_rdy), 32'd0);
    tick();
    @(negedge clk);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_nz_cnt", 32'(dut.nz_cnt), 32'd0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      znz = tbl[i].z; znz_vld = tbl[i].zv; bpc_vld = tbl[i].bv;
      #1;
      check("tbl_znz_rdy", 32'(znz_rdy), 32'(tbl[i].e_zr));
      check("tbl_bpc_rdy", 32'(bpc_rdy), 32'(tbl[i].e_br));
      znz = 1'b0; znz_vld = 1'b0; bpc_vld = 1'b0;
    end
    tick();

    // BLOCK_SIZE=2 instance: 0,1,0,1 needs no padding
    s_znz_vld = 1'b1; s_bpc_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_znz = (i % 2 == 1); s_last_in = (i == 3); s_bpc = s_words[i];
      @(negedge clk);
      check("s_znz_rdy", 32'(s_znz_rdy), 32'd1);
      if (i > 0) begin
        check("s_data", 32'(s_data), 32'(s_words[i-1]));
        check("s_last", 32'(s_last), 32'd0);
      end
      tick();
    end
    s_znz_vld = 1'b0; s_bpc_vld = 1'b0;
    @(negedge clk);
    check("s_data_end", 32'(s_data), 32'h22);
    check("s_last_end", 32'(s_last), 32'd1);
    check("s_vld_end", 32'(s_vld), 32'd1);
    check("s_nz_cnt", 32'(dut_small.nz_cnt), 32'd0);
    check("s_not_drain", 32'(s_bpc_rdy), 32'd0);
    tick();

    // three non-zero words then five padding words in DRAIN
    do_reset();
    flag_q.push_back(2'b10); flag_q.push_back(2'b10); flag_q.push_back(2'b11);
    for (int i = 0; i < 8; i++) bpc_q.push_back(DW'(8'hC0 + i));
    exp_q.push_back({1'b0, 8'hC0}); exp_q.push_back({1'b0, 8'hC1}); exp_q.push_back({1'b1, 8'hC2});
    run_stream(0, 0);

    // word starvation then output backpressure
    do_reset();
    rdy = 1'b1;
    znz = 1'b1; znz_last = 1'b0; znz_vld = 1'b1; bpc = 8'hA5; bpc_vld = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("starve_znz_rdy", 32'(znz_rdy), 32'd0);
      check("starve_vld", 32'(vld), 32'd0);
      tick();
    end
    bpc_vld = 1'b1;
    @(negedge clk);
    check("resume_znz_rdy", 32'(znz_rdy), 32'd1);
    tick();
    bpc = 8'h5A; rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_data", 32'(data), 32'hA5);
      check("hold_last", 32'(last), 32'd0);
      check("hold_vld", 32'(vld), 32'd1);
      check("hold_znz_rdy", 32'(znz_rdy), 32'd0);
      check("hold_bpc_rdy", 32'(bpc_rdy), 32'd0);
      tick();
    end
    rdy = 1'b1;
    @(negedge clk);
    check("release_znz_rdy", 32'(znz_rdy), 32'd1);
    tick();
    znz = 1'b0; znz_last = 1'b1; bpc_vld = 1'b0;
    @(negedge clk);
    check("after_release", 32'(data), 32'h5A);
    check("after_rel_vld", 32'(vld), 32'd1);
    tick();
    znz_vld = 1'b0;
    @(negedge clk);
    check("zero_last_data", 32'(data), 32'd0);
    check("zero_last_flag", 32'(last), 32'd1);
    check("drain_entered", 32'(bpc_rdy), 32'd1);
    tick();
    @(negedge clk);
    check("drain_pop_vld", 32'(vld), 32'd0);
    tick();
    repeat (6) bpc_q.push_back(8'hEE);
    drive_bpc(0);
    @(negedge clk);
    check("drain_exit_cnt", 32'(dut.nz_cnt), 32'd0);
    check("drain_exit_run", 32'(bpc_rdy), 32'd0);
    tick();

    // clear while draining with three words in the block
    do_reset();
    rdy = 1'b1; znz_vld = 1'b1; bpc_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      znz = 1'b1; znz_last = (i == 2); bpc = DW'(8'h30 + i);
      @(negedge clk);
      if (i > 0) check("clr_pre_data", 32'(data), 32'(8'h30 + i - 1));
      check("clr_pre_znz_rdy", 32'(znz_rdy), 32'd1);
      tick();
    end
    znz_vld = 1'b0; bpc_vld = 1'b0;
    @(negedge clk);
    check("clr_pre_last", 32'(last), 32'd1);
    check("clr_pre_cnt", 32'(dut.nz_cnt), 32'd3);
    check("clr_pre_drain", 32'(bpc_rdy), 32'd1);
    znz_vld = 1'b1;
    #1;
    check("drain_znz_rdy", 32'(znz_rdy), 32'd0);
    znz_vld = 1'b0;
    clr = 1'b1;
    #1;
    check("clr_bpc_rdy", 32'(bpc_rdy), 32'd0);
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_cnt", 32'(dut.nz_cnt), 32'd0);
    check("clr_vld", 32'(vld), 32'd0);
    check("clr_run", 32'(bpc_rdy), 32'd0);
    tick();
    add_stream(12, 50);
    run_stream(20, 20);

    // long random run with stalls on every port
    do_reset();
    total = 0;
    while (total < 10000) begin
      int n;
      n = int'($urandom_range(1, 40));
      add_stream(n, int'($urandom_range(0, 100)));
      total += n;
    end
    run_stream(30, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
